multi_port_register_file: RTL and testbench
===========================================

MULTI_PORT_REGISTER_FILE -- requirements
Module: multi_port_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits, legal range 1 or more.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count, legal range 2 or more, not restricted to powers of 2.
REQ-003 SHALL have parameter NUM_READ_PORTS, default 2: count of combinational read ports, legal range 1-4.
REQ-004 SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1: when 1, the write value is forwarded to matching read ports in the same cycle.
REQ-006 SHALL define AW = max(1, clog2(NUM_REGS)).
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 rs_addr  in  NUM_READ_PORTS*AW  packed read addresses; port p occupies bits [p*AW +: AW].
REQ-010 rs_data  out  NUM_READ_PORTS*XLEN  packed read data; port p occupies bits [p*XLEN +: XLEN].
REQ-011 rd_addr  in  AW  write address.
REQ-012 rd_data  in  XLEN  write data.
REQ-013 rd_we  in  1  write enable.
REQ-014 clear_req  in  1  single-cycle request to start a sequential clear of all registers.
REQ-015 busy  out  1  high while a sequential clear is in progress.
REQ-016 dbg_addr  in  AW  debug read address.
REQ-017 dbg_data  out  XLEN  registered debug read data.
REQ-018 reg_last  out  XLEN  continuous view of register NUM_REGS-1.

Function
REQ-019 Storage SHALL be NUM_REGS x XLEN flops.
REQ-020 Write SHALL occur on the rising edge when all hold: rd_we=1, busy=0, rd_addr<NUM_REGS, and not (ZERO_REG=1 and rd_addr=0); otherwise the write is dropped.
REQ-021 rs_data port p SHALL be combinational: stored value of rs_addr[p], or 0 when rs_addr[p]>=NUM_REGS or (ZERO_REG=1 and rs_addr[p]=0).
REQ-022 When BYPASS=1 and a write qualifies per REQ-020 with rd_addr=rs_addr[p], port p SHALL return rd_data in the same cycle; when BYPASS=0, port p SHALL return the old value.
REQ-023 dbg_data SHALL be loaded each rising edge with the pre-write stored value at dbg_addr (1-cycle latency, no bypass); it SHALL load 0 when dbg_addr is out of range.
REQ-024 reg_last SHALL equal stored register NUM_REGS-1 and SHALL NOT be bypassed.
REQ-025 Clear FSM SHALL have two states: IDLE (busy=0) and CLEARING (busy=1), with an AW-bit index counter.
REQ-026 IDLE->CLEARING SHALL occur on an edge with clear_req=1, setting index=0; a write qualifying per REQ-020 on that same edge SHALL still be performed.
REQ-027 In CLEARING, each edge SHALL zero register[index] and increment index; on the edge where index=NUM_REGS-1, the FSM SHALL return to IDLE; busy SHALL be high for exactly NUM_REGS cycles.
REQ-028 clear_req SHALL be ignored in CLEARING; writes SHALL be dropped in CLEARING; reads SHALL return current, partially cleared contents.
REQ-029 The index SHALL never exceed NUM_REGS-1; no wrap into unused codes for non-power-of-2 NUM_REGS.

Reset
REQ-030 While reset=1, independent of clock: all registers=0, state=IDLE, index=0, busy=0, dbg_data=0; hence rs_data=0 and reg_last=0.
REQ-031 Reset asserted mid-clear SHALL abort the clear; after release the block SHALL be IDLE and accept writes on the first edge.

Verification
REQ-032 Defaults: write 0xDEADBEEF to reg 5, then read rs_addr0=5 -> rs_data0=0xDEADBEEF; write 0x1234 to reg 0 -> reg 0 reads 0.
REQ-033 Bypass: rd_we=1, rd_addr=7, rd_data=0xA5A5A5A5, rs_addr1=7 in the same cycle -> rs_data1=0xA5A5A5A5 before the edge; with BYPASS=0 -> old value.
REQ-034 Clear: fill regs 1-31 with nonzero values, pulse clear_req -> busy high for 32 cycles; reg 31 (reg_last) reads 0 after the 32nd CLEARING edge; a write attempted during busy is dropped.
REQ-035 NUM_REGS=20, XLEN=16, NUM_READ_PORTS=3: clear -> busy for 20 cycles with no index overrun; rs_addr=25 -> rs_data=0; write to address 25 ignored.
REQ-036 Reset asserted at CLEARING cycle 10 -> busy=0 immediately and all registers 0; write of 0x55 to reg 3 on the first edge after release -> reg 3 reads 0x55 and dbg_data shows it one cycle after dbg_addr=3.

Source files
------------

// File: rtl/multi_port_register_file.sv
// Parameterised register file: N combinational read ports with optional write bypass,
// one write port, a registered debug read, and a sequential one-register-per-cycle clear.
module multi_port_register_file #(
    parameter int XLEN           = 32,
    parameter int NUM_REGS       = 32,
    parameter int NUM_READ_PORTS = 2,
    parameter bit ZERO_REG       = 1'b1,
    parameter bit BYPASS         = 1'b1,
    localparam int AW            = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_READ_PORTS*AW-1:0]   rs_addr,
    output logic [NUM_READ_PORTS*XLEN-1:0] rs_data,
    input  logic [AW-1:0]                  rd_addr,
    input  logic [XLEN-1:0]                rd_data,
    input  logic                           rd_we,
    input  logic                           clear_req,
    output logic                           busy,
    input  logic [AW-1:0]                  dbg_addr,
    output logic [XLEN-1:0]                dbg_data,
    output logic [XLEN-1:0]                reg_last
);

    typedef enum logic {
        IDLE,
        CLEARING
    } state_e;

    localparam logic [AW:0]   NUM_REGS_W = (AW + 1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_REGS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];
    logic [XLEN-1:0] dbg_data_q, dbg_data_d;
    logic            write_ok;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < NUM_REGS_W;
    endfunction

    // Addresses that hold real storage: in range and not the hardwired zero register.
    function automatic logic addr_valid(input logic [AW-1:0] addr);
        return in_range(addr) && !(ZERO_REG && (addr == '0));
    endfunction

    assign busy = (state_q == CLEARING);

    // Gating with reset keeps the bypass path from leaking rd_data while the file is held clear.
    assign write_ok = rd_we && !busy && !reset && addr_valid(rd_addr);

    // NOTE: combinational blocks use blocking '=' with every output defaulted first (no latches);
    // the flop block below uses non-blocking '<=' only.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        unique case (state_q)
            IDLE: begin
                if (write_ok) begin
                    regs_d[rd_addr] = rd_data;
                end
                if (clear_req) begin
                    state_d = CLEARING;
                    idx_d   = '0;
                end
            end
            CLEARING: begin
                regs_d[idx_q] = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Debug port samples the stored (pre-write) contents; no bypass here.
    always_comb begin
        dbg_data_d = '0;
        if (in_range(dbg_addr)) begin
            dbg_data_d = regs_q[dbg_addr];
        end
    end

    // NOTE: the whole array is reset because every register must read zero while reset is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            dbg_data_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dbg_data_q <= dbg_data_d;
            regs_q     <= regs_d;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        logic [AW-1:0]   port_addr;
        logic [XLEN-1:0] port_data;

        assign port_addr = rs_addr[p*AW +: AW];

        always_comb begin
            port_data = '0;
            if (BYPASS && write_ok && (rd_addr == port_addr)) begin
                port_data = rd_data;
            end else if (addr_valid(port_addr)) begin
                port_data = regs_q[port_addr];
            end
        end

        assign rs_data[p*XLEN +: XLEN] = port_data;
    end

    assign dbg_data = dbg_data_q;
    assign reg_last = regs_q[NUM_REGS-1];

endmodule

// File: tb/tb_multi_port_register_file.sv
// Bench for multi_port_register_file: two configurations driven by shared random stimulus,
// checked every cycle against a behavioural register-file model, plus directed literal cases.
module tb_multi_port_register_file;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs_sel [3];
    logic [9:0]  rs_addr_a;
    logic [14:0] rs_addr_b;
    logic [4:0]  rd_addr;
    logic [4:0]  dbg_addr;
    logic [31:0] rd_data;
    logic        rd_we;
    logic        clear_req;

    logic [63:0] rs_data_a;
    logic [47:0] rs_data_b;
    logic        busy_a, busy_b;
    logic [31:0] dbg_a, last_a;
    logic [15:0] dbg_b, last_b;

    int n_checks = 0;
    int n_pass   = 0;

    assign rs_addr_a = {rs_sel[1], rs_sel[0]};
    assign rs_addr_b = {rs_sel[2], rs_sel[1], rs_sel[0]};

    always #5 clock = ~clock;

    multi_port_register_file #(
        .XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset), .rs_addr(rs_addr_a), .rs_data(rs_data_a),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we), .clear_req(clear_req),
        .busy(busy_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a), .reg_last(last_a)
    );

    multi_port_register_file #(
        .XLEN(16), .NUM_REGS(20), .NUM_READ_PORTS(3), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_b (
        .clock(clock), .reset(reset), .rs_addr(rs_addr_b), .rs_data(rs_data_b),
        .rd_addr(rd_addr), .rd_data(rd_data[15:0]), .rd_we(rd_we), .clear_req(clear_req),
        .busy(busy_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b), .reg_last(last_b)
    );

    // Reference model: index 0 = configuration A, index 1 = configuration B.
    int          nregs    [2] = '{32, 20};
    bit          zero_cfg [2] = '{1'b1, 1'b0};
    bit          byp_cfg  [2] = '{1'b1, 1'b0};
    logic [31:0] mask_cfg [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] mem      [2][32];
    bit          clr      [2];
    int          cidx     [2];
    logic [31:0] dbg_exp  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit qual(input int c);
        return !reset && rd_we && !clr[c] && (int'(rd_addr) < nregs[c])
               && !(zero_cfg[c] && (rd_addr == 5'd0));
    endfunction

    function automatic logic [31:0] exp_read(input int c, input logic [4:0] a);
        if (byp_cfg[c] && qual(c) && (rd_addr == a)) return rd_data & mask_cfg[c];
        if ((int'(a) >= nregs[c]) || (zero_cfg[c] && (a == 5'd0))) return 32'd0;
        return mem[c][a];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 32; i++) mem[c][i] = 32'd0;
                clr[c]     = 1'b0;
                cidx[c]    = 0;
                dbg_exp[c] = 32'd0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                dbg_exp[c] = (int'(dbg_addr) < nregs[c]) ? mem[c][dbg_addr] : 32'd0;
                if (clr[c]) begin
                    mem[c][cidx[c]] = 32'd0;
                    if (cidx[c] == nregs[c] - 1) clr[c] = 1'b0;
                    else cidx[c]++;
                end else begin
                    if (qual(c)) mem[c][rd_addr] = rd_data & mask_cfg[c];
                    if (clear_req) begin
                        clr[c]  = 1'b1;
                        cidx[c] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        check("a_busy", 32'(busy_a), 32'(clr[0]));
        check("b_busy", 32'(busy_b), 32'(clr[1]));
        check("a_dbg", dbg_a, dbg_exp[0]);
        check("b_dbg", 32'(dbg_b), dbg_exp[1]);
        check("a_last", last_a, mem[0][31]);
        check("b_last", 32'(last_b), mem[1][19]);
        for (int p = 0; p < 2; p++)
            check($sformatf("a_rs%0d", p), rs_data_a[p*32 +: 32], exp_read(0, rs_sel[p]));
        for (int p = 0; p < 3; p++)
            check($sformatf("b_rs%0d", p), 32'(rs_data_b[p*16 +: 16]), exp_read(1, rs_sel[p]));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic randomize_inputs();
        rd_we     = ($urandom_range(0, 3) != 0);
        rd_addr   = 5'($urandom_range(0, 31));
        rd_data   = $urandom;
        clear_req = ($urandom_range(0, 39) == 0);
        dbg_addr  = 5'($urandom_range(0, 31));
        for (int p = 0; p < 3; p++) rs_sel[p] = 5'($urandom_range(0, 31));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a, cnt_b;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) mem[c][i] = 32'd0;
            clr[c] = 1'b0; cidx[c] = 0; dbg_exp[c] = 32'd0;
        end
        rd_we = 1'b0; rd_addr = '0; rd_data = '0; clear_req = 1'b0; dbg_addr = '0;
        for (int p = 0; p < 3; p++) rs_sel[p] = '0;

        // Reset state.
        @(negedge clock);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_last", last_a, 32'd0);
        check("rst_dbg", dbg_a, 32'd0);
        check("rst_rs", rs_data_a[31:0], 32'd0);
        #1 reset = 1'b0;
        tick();

        // Basic write/read and the hardwired zero register.
        rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF;
        tick();
        rd_addr = 5'd0; rd_data = 32'h0000_1234; rs_sel[0] = 5'd5;
        @(negedge clock);
        check("lit_a_r5", rs_data_a[31:0], 32'hDEAD_BEEF);
        check("lit_b_r5", 32'(rs_data_b[15:0]), 32'h0000_BEEF);
        tick();
        rd_we = 1'b0; rs_sel[0] = 5'd0;
        @(negedge clock);
        check("lit_a_r0", rs_data_a[31:0], 32'd0);
        check("lit_b_r0", 32'(rs_data_b[15:0]), 32'h0000_1234);
        tick();

        // Same-cycle bypass (A) versus old value (B).
        rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'h1111_1111;
        tick();
        rd_data = 32'hA5A5_A5A5; rs_sel[1] = 5'd7;
        @(negedge clock);
        check("lit_a_byp", rs_data_a[63:32], 32'hA5A5_A5A5);
        check("lit_b_nobyp", 32'(rs_data_b[31:16]), 32'h0000_1111);
        tick();
        rd_we = 1'b0;
        @(negedge clock);
        check("lit_b_after", 32'(rs_data_b[31:16]), 32'h0000_A5A5);
        tick();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            tick();
        end
        rd_we = 1'b0; clear_req = 1'b0;
        for (int k = 0; k < 64 && (busy_a || busy_b); k++) tick();
        check("idle_a", 32'(busy_a), 32'd0);
        check("idle_b", 32'(busy_b), 32'd0);

        // Fill, then sequential clear with a dropped write and an ignored second request.
        for (int i = 1; i < 32; i++) begin
            rd_we = 1'b1; rd_addr = 5'(i); rd_data = (32'(i) << 24) | 32'h00C0_FFEE;
            tick();
        end
        rd_we = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0; rd_we = 1'b1; rd_addr = 5'd9; rd_data = 32'hBAD0_BAD0;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            if (k == 31) check("lit_last_pre", last_a, 32'h1FC0_FFEE);
            if (k == 32) check("lit_last_clr", last_a, 32'd0);
            @(posedge clock);
            #1;
            rd_we = 1'b0;
            clear_req = (k == 4);
        end
        check("busy_cycles_a", 32'(cnt_a), 32'd32);
        check("busy_cycles_b", 32'(cnt_b), 32'd20);
        rs_sel[0] = 5'd9;
        @(negedge clock);
        check("lit_a_drop9", rs_data_a[31:0], 32'd0);
        check("lit_b_drop9", 32'(rs_data_b[15:0]), 32'd0);
        tick();

        // Out-of-range address 25 on the 20-entry instance.
        for (int p = 0; p < 3; p++) rs_sel[p] = 5'd25;
        dbg_addr = 5'd25; rd_we = 1'b1; rd_addr = 5'd25; rd_data = 32'h600D_600D;
        @(negedge clock);
        check("lit_a_r25", rs_data_a[31:0], 32'h600D_600D);
        check("lit_b_r25", 32'(rs_data_b[47:32]), 32'd0);
        tick();
        rd_we = 1'b0;
        tick();
        @(negedge clock);
        check("lit_a_dbg25", dbg_a, 32'h600D_600D);
        check("lit_b_dbg25", 32'(dbg_b), 32'd0);
        tick();

        // Reset in the middle of a clear, then a write on the first edge after release.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (9) tick();
        @(negedge clock);
        check("lit_mid_busy", 32'(busy_a), 32'd1);
        check("lit_mid_r25", rs_data_a[31:0], 32'h600D_600D);
        #2 reset = 1'b1;
        #1;
        check("lit_rst_busy_a", 32'(busy_a), 32'd0);
        check("lit_rst_busy_b", 32'(busy_b), 32'd0);
        check("lit_rst_r25", rs_data_a[31:0], 32'd0);
        check("lit_rst_dbg", dbg_a, 32'd0);
        @(negedge clock);
        #1 reset = 1'b0;
        rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'h0000_0055;
        tick();
        rd_we = 1'b0; dbg_addr = 5'd3; rs_sel[0] = 5'd3;
        @(negedge clock);
        check("lit_a_r3", rs_data_a[31:0], 32'h0000_0055);
        check("lit_b_r3", 32'(rs_data_b[15:0]), 32'h0000_0055);
        check("lit_dbg_lag", dbg_a, 32'd0);
        tick();
        @(negedge clock);
        check("lit_a_dbg3", dbg_a, 32'h0000_0055);
        check("lit_b_dbg3", 32'(dbg_b), 32'h0000_0055);
        tick();

        for (int i = 0; i < 150; i++) begin
            randomize_inputs();
            tick();
        end
        rd_we = 1'b0; clear_req = 1'b0;
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
